gfx_sp_fetch: RTL

Operand-fetch sequencer for the shader processor. It accepts one instruction's source/destination register numbers and drives the single-port vector register file's read side, which has a fixed 3-cycle read latency. It collects one or two vec4 operands and presents them downstream with a valid/ready handshake. It also owns the file's write side: writeback is passed through to the file, with same-cycle write-to-read forwarding.

---
 rtl/gfx_sp_fetch_if.sv | 52 +++++
 rtl/gfx_sp_fetch.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/gfx_sp_fetch_if.sv
// Handshake and register-file bundle for the shader-processor operand fetcher.
// master = upstream/downstream/register-file side, slave = gfx_sp_fetch.
interface gfx_sp_fetch_if #(
  parameter int VREG_W = 5,
  parameter int VEC_W  = 32
);
  // instruction request
  logic                       in_valid;
  logic                       in_ready;
  logic [VREG_W-1:0]          in_src_a;
  logic [VREG_W-1:0]          in_src_b;
  logic                       in_two_src;
  logic [VREG_W-1:0]          in_dst;
  // operand response
  logic                       out_valid;
  logic                       out_ready;
  logic [3:0][VEC_W-1:0]      out_op_a;
  logic [3:0][VEC_W-1:0]      out_op_b;
  logic [VREG_W-1:0]          out_dst;
  // register file read side
  logic [VREG_W-1:0]          rf_rd_reg;
  logic [3:0][VEC_W-1:0]      rf_rd_data;
  // writeback in, register file write side out
  logic                       wb_valid;
  logic [VREG_W-1:0]          wb_reg;
  logic [3:0][VEC_W-1:0]      wb_data;
  logic                       rf_wr;
  logic [VREG_W-1:0]          rf_wr_reg;
  logic [3:0][VEC_W-1:0]      rf_wr_data;

  modport master (
    output in_valid, in_src_a, in_src_b, in_two_src, in_dst,
    input  in_ready,
    input  out_valid, out_op_a, out_op_b, out_dst,
    output out_ready,
    input  rf_rd_reg,
    output rf_rd_data,
    output wb_valid, wb_reg, wb_data,
    input  rf_wr, rf_wr_reg, rf_wr_data
  );

  modport slave (
    input  in_valid, in_src_a, in_src_b, in_two_src, in_dst,
    output in_ready,
    output out_valid, out_op_a, out_op_b, out_dst,
    input  out_ready,
    output rf_rd_reg,
    input  rf_rd_data,
    input  wb_valid, wb_reg, wb_data,
    output rf_wr, rf_wr_reg, rf_wr_data
  );
endinterface

// File: rtl/gfx_sp_fetch.sv
// Operand-fetch sequencer: issues one or two reads to a fixed-latency vector
// register file, collects the returns, and hands the operands downstream.
module gfx_sp_fetch #(
  parameter int RD_LAT = 3,
  parameter int VREG_W = 5,
  parameter int VEC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  gfx_sp_fetch_if.slave   bus
);

  typedef logic [3:0][VEC_W-1:0] vec4_t;
  typedef logic [VREG_W-1:0]     vreg_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE_A = 3'd1;
  localparam logic [2:0] S_ISSUE_B = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  localparam logic SLOT_A = 1'b0;
  localparam logic SLOT_B = 1'b1;

  logic [2:0] state_q, state_d;

  vreg_t  src_a_q, src_a_d;
  vreg_t  src_b_q, src_b_d;
  logic   two_src_q, two_src_d;
  vreg_t  dst_q, dst_d;
  vreg_t  rd_reg_q, rd_reg_d;
  vec4_t  op_a_q, op_a_d;
  vec4_t  op_b_q, op_b_d;

  // Return tracker: index k holds the read issued k cycles ago.
  logic  [RD_LAT:1] vld_pipe_q;
  logic  [RD_LAT:1] slot_pipe_q;
  logic  [RD_LAT:1] hit_pipe_q;
  vec4_t            fdat_pipe_q [RD_LAT:1];

  logic  in_fire, out_fire;
  logic  issue, issue_slot, issue_hit;
  logic  ret_vld, ret_slot, ret_last;
  vec4_t ret_data;

  // Writeback passes straight through to the file; it never stalls.
  assign bus.rf_wr      = bus.wb_valid;
  assign bus.rf_wr_reg  = bus.wb_reg;
  assign bus.rf_wr_data = bus.wb_data;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_op_a  = op_a_q;
  assign bus.out_op_b  = op_b_q;
  assign bus.out_dst   = dst_q;
  assign bus.rf_rd_reg = rd_reg_q;

  assign in_fire  = bus.in_ready  && bus.in_valid;
  assign out_fire = bus.out_valid && bus.out_ready;

  // The file returns pre-write contents for a same-cycle write, so a
  // matching writeback during issue is the value the instruction must see.
  assign issue      = (state_q == S_ISSUE_A) || (state_q == S_ISSUE_B);
  assign issue_slot = (state_q == S_ISSUE_B) ? SLOT_B : SLOT_A;
  assign issue_hit  = issue && bus.wb_valid && (bus.wb_reg == rd_reg_q);

  assign ret_vld  = vld_pipe_q[RD_LAT];
  assign ret_slot = slot_pipe_q[RD_LAT];
  assign ret_data = hit_pipe_q[RD_LAT] ? fdat_pipe_q[RD_LAT] : bus.rf_rd_data;
  assign ret_last = ret_vld && ((ret_slot == SLOT_B) || !two_src_q);

  always_comb begin
    state_d   = state_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    two_src_d = two_src_q;
    dst_d     = dst_q;
    rd_reg_d  = rd_reg_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;

    if (ret_vld) begin
      if (ret_slot == SLOT_B) op_b_d = ret_data;
      else                    op_a_d = ret_data;
    end

    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          src_a_d   = bus.in_src_a;
          src_b_d   = bus.in_src_b;
          two_src_d = bus.in_two_src;
          dst_d     = bus.in_dst;
          rd_reg_d  = bus.in_src_a;
          op_a_d    = '0;
          op_b_d    = '0;
          state_d   = S_ISSUE_A;
        end
      end
      S_ISSUE_A: begin
        if (two_src_q) begin
          rd_reg_d = src_b_q;
          state_d  = S_ISSUE_B;
        end else begin
          state_d  = S_WAIT;
        end
      end
      S_ISSUE_B: state_d = S_WAIT;
      S_WAIT:    if (ret_last) state_d = S_OUT;
      S_OUT:     if (out_fire) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_a_q   <= '0;
      src_b_q   <= '0;
      two_src_q <= 1'b0;
      dst_q     <= '0;
      rd_reg_q  <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state_q   <= state_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      two_src_q <= two_src_d;
      dst_q     <= dst_d;
      rd_reg_q  <= rd_reg_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      slot_pipe_q <= '0;
      hit_pipe_q  <= '0;
      for (int k = 1; k <= RD_LAT; k++) fdat_pipe_q[k] <= '0;
    end else begin
      vld_pipe_q[1]  <= issue;
      slot_pipe_q[1] <= issue_slot;
      hit_pipe_q[1]  <= issue_hit;
      fdat_pipe_q[1] <= bus.wb_data;
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe_q[k]  <= vld_pipe_q[k-1];
        slot_pipe_q[k] <= slot_pipe_q[k-1];
        hit_pipe_q[k]  <= hit_pipe_q[k-1];
        fdat_pipe_q[k] <= fdat_pipe_q[k-1];
      end
    end
  end

endmodule
